reg_write_ctrl: RTL and testbench

Upstream input stage for the register-file/display system. It turns the raw write push-button, the clear push-button, and the address/data slide switches into clean write commands for the register bank. It drives `addrW`, `datW` and `RegWrite` into the bank, which is an 8x4-bit register file.
- A write press produces a single one-cycle write of the switch values.
- A clear press produces an 8-cycle burst that writes 0 to every register.

---
 rtl/reg_write_ctrl.sv | 139 +++++++++++++
 tb/tb_reg_write_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_ctrl.sv
// Debounced write/clear push-button front end for an 8x4 register bank.
// Write strobe lands DEBOUNCE_CYCLES+3 edges after a clean press; presses while busy are dropped.
module reg_write_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ADDR_W          = 3,
    parameter int DATA_W          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_wr,
    input  logic              btn_clr,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [DATA_W-1:0] sw_dat,
    output logic [ADDR_W-1:0] addrW,
    output logic [DATA_W-1:0] datW,
    output logic              RegWrite,
    output logic              busy
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WRITE    = 2'd1;
    localparam logic [1:0] CLEAR    = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

    // Button index 0 is write, index 1 is clear.
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       db_q, db_d;
    logic [1:0]       db_prev_q, db_prev_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic              we_q, we_d;

    logic wr_evt, clr_evt;

    always_comb begin
        sync1_d   = {btn_clr, btn_wr};
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    assign wr_evt  = db_q[0] & ~db_prev_q[0];
    assign clr_evt = db_q[1] & ~db_prev_q[1];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dat_d   = dat_q;
        we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_evt) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                    dat_d   = '0;
                    we_d    = 1'b1;
                end else if (wr_evt) begin
                    state_d = WRITE;
                    addr_d  = sw_addr;
                    dat_d   = sw_dat;
                    we_d    = 1'b1;
                end
            end
            WRITE: begin
                state_d = WAIT_REL;
            end
            CLEAR: begin
                // Last address written holds on the bus once the burst ends.
                if (addr_q == ADDR_MAX) begin
                    state_d = WAIT_REL;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                    dat_d  = '0;
                    we_d   = 1'b1;
                end
            end
            default: begin
                if (db_q == 2'b00) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            state_q   <= IDLE;
            addr_q    <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q   <= state_d;
            addr_q    <= addr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
        end
    end

    assign addrW    = addr_q;
    assign datW     = dat_q;
    assign RegWrite = we_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Scoreboard bench for reg_write_ctrl with a 4-cycle debounce.
module tb_reg_write_ctrl;

    localparam int DC  = 4;
    localparam int LAT = DC + 3;

    logic       clk;
    logic       rst;
    logic       btn_wr;
    logic       btn_clr;
    logic [2:0] sw_addr;
    logic [3:0] sw_dat;
    logic [2:0] addrW;
    logic [3:0] datW;
    logic       RegWrite;
    logic       busy;

    typedef struct {
        int         cyc;
        logic [2:0] a;
        logic [3:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    reg_write_ctrl #(
        .DEBOUNCE_CYCLES(DC),
        .ADDR_W(3),
        .DATA_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_wr(btn_wr),
        .btn_clr(btn_clr),
        .sw_addr(sw_addr),
        .sw_dat(sw_dat),
        .addrW(addrW),
        .datW(datW),
        .RegWrite(RegWrite),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: every strobe must match the head of the expectation queue, cycle included.
    always @(negedge clk) begin
        exp_t e;
        if (RegWrite === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_strobe cyc=%0d addrW=%0d datW=%0h, required no strobe",
                         cyc, addrW, datW);
            end else begin
                e = exp_q.pop_front();
                if (cyc != e.cyc || addrW !== e.a || datW !== e.d) begin
                    n_fail++;
                    $display("FAIL strobe cyc=%0d addrW=%0d datW=%0h, required cyc=%0d addrW=%0d datW=%0h",
                             cyc, addrW, datW, e.cyc, e.a, e.d);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            n_checks++;
            n_fail++;
            e = exp_q.pop_front();
            $display("FAIL missed_strobe cyc=%0d RegWrite=%0b, required strobe addrW=%0d datW=%0h",
                     cyc, RegWrite, e.a, e.d);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    task automatic push_clear(input int base, input int count);
        for (int k = 0; k < count; k++) begin
            exp_q.push_back('{cyc: base + LAT + k, a: 3'(k), d: 4'h0});
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            tick(1);
            k++;
        end
        chk(name, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        int r;
        rst     = 1'b0;
        btn_wr  = 1'b0;
        btn_clr = 1'b0;
        sw_addr = 3'd0;
        sw_dat  = 4'h0;

        // Reset with buttons toggling.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_addrW", {5'd0, addrW}, 8'd0);
            chk("rst_datW", {4'd0, datW}, 8'd0);
            chk("rst_RegWrite", {7'd0, RegWrite}, 8'd0);
            chk("rst_busy", {7'd0, busy}, 8'd0);
            btn_wr  = ~btn_wr;
            btn_clr = (i == 1);
        end
        rst     = 1'b1;
        btn_wr  = 1'b0;
        btn_clr = 1'b0;
        tick(1);
        chk("post_rst_RegWrite", {7'd0, RegWrite}, 8'd0);
        chk("post_rst_busy", {7'd0, busy}, 8'd0);
        tick(3);

        // Single write, held for 20 cycles.
        sw_addr = 3'd5;
        sw_dat  = 4'hA;
        btn_wr  = 1'b1;
        exp_q.push_back('{cyc: cyc + LAT, a: 3'd5, d: 4'hA});
        tick(LAT - 1);
        chk("wr_busy_before", {7'd0, busy}, 8'd0);
        tick(2);
        chk("wr_busy_after", {7'd0, busy}, 8'd1);
        sw_addr = 3'd1;
        sw_dat  = 4'h3;
        tick(12);
        chk("wr_hold_addrW", {5'd0, addrW}, 8'd5);
        chk("wr_hold_datW", {4'd0, datW}, 8'hA);
        btn_wr = 1'b0;
        r = cyc;
        tick(DC + 2);
        chk("rel_busy_still", {7'd0, busy}, 8'd1);
        tick(1);
        chk("rel_busy_clear", {7'd0, busy}, 8'd0);
        tick(3);

        // Bounce shorter than the debounce window.
        btn_wr = 1'b1; tick(3);
        btn_wr = 1'b0; tick(2);
        btn_wr = 1'b1; tick(2);
        btn_wr = 1'b0; tick(15);
        chk("bounce_busy", {7'd0, busy}, 8'd0);

        // Clear burst.
        btn_clr = 1'b1;
        r = cyc;
        push_clear(r, 8);
        tick(LAT - 1);
        chk("clr_busy_before", {7'd0, busy}, 8'd0);
        tick(1);
        chk("clr_busy_first", {7'd0, busy}, 8'd1);
        tick(12);
        chk("clr_end_addrW", {5'd0, addrW}, 8'd7);
        chk("clr_end_busy", {7'd0, busy}, 8'd1);
        btn_clr = 1'b0;
        wait_idle("clr_idle");
        tick(3);

        // Simultaneous press: clear only.
        sw_addr = 3'd2;
        sw_dat  = 4'hF;
        btn_wr  = 1'b1;
        btn_clr = 1'b1;
        push_clear(cyc, 8);
        tick(20);
        btn_wr  = 1'b0;
        btn_clr = 1'b0;
        wait_idle("simul_idle");
        tick(3);

        // Write pressed during a clear burst is ignored.
        btn_clr = 1'b1;
        r = cyc;
        push_clear(r, 8);
        tick(LAT + 2);
        btn_wr = 1'b1;
        tick(12);
        btn_wr  = 1'b0;
        btn_clr = 1'b0;
        wait_idle("during_idle");
        tick(10);

        // Reset in the middle of a clear burst, at addrW=3.
        btn_clr = 1'b1;
        r = cyc;
        push_clear(r, 4);
        tick(LAT + 3);
        chk("midclr_addrW", {5'd0, addrW}, 8'd3);
        rst     = 1'b0;
        btn_clr = 1'b0;
        tick(1);
        chk("midclr_rst_RegWrite", {7'd0, RegWrite}, 8'd0);
        chk("midclr_rst_addrW", {5'd0, addrW}, 8'd0);
        chk("midclr_rst_busy", {7'd0, busy}, 8'd0);
        tick(2);
        rst = 1'b1;
        tick(20);
        chk("midclr_after_busy", {7'd0, busy}, 8'd0);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain pending=%0d required=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
